// File: rtl/pattern_count_engine.sv
`default_nettype none
// ============================================================================
// Module   : pattern_count_engine
// Brief    : Scans a contiguous range of data memory through a one-cycle
//            latency read port and counts PW-bit pattern matches inside each
//            DW-bit word (per word or per window position).
// Option   : PATCNT_CROSS_BYTE_EN - also count windows that straddle two
//            consecutive words of the same run.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_count_engine #(
  parameter int DW = 8,
  parameter int PW = 4,
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [AW-1:0] i_length,
  input  logic [PW-1:0] i_pattern,
  input  logic          i_mode,
  output logic          o_mem_rd,
  output logic [AW-1:0] o_mem_addr,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_count
);

  // Sum width: wide enough that count plus one word's increment never overflows.
  localparam int            SW    = CW + DW + 1;
  localparam logic [CW-1:0] c_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;

  logic [PW-1:0] r_pattern;
  logic          r_mode;
  logic [AW-1:0] r_left;      // reads still to issue after the current one
  logic [AW-1:0] r_addr;
  logic          r_mem_rd;
  logic          r_vld;       // i_mem_rdata carries a word to evaluate
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_count;

  logic [SW-1:0] w_inc;
  logic          w_any;
  logic [SW-1:0] w_sum;
  logic [CW-1:0] w_count_nxt;

`ifdef PATCNT_CROSS_BYTE_EN
  logic [DW-1:0]   r_prev;
  logic            r_have_prev;
  logic [2*DW-1:0] w_cat;
`endif

  // A new search may be accepted when idle or on the edge that ends DONE.
  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (i_length == '0) ? DRAIN : RUN;
      RUN:     if (r_left == '0) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = DONE;
      DONE:    if (w_accept) w_state_nxt = (i_length == '0) ? DRAIN : RUN;
               else          w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Match count for the returned word and the saturated running total.
  always_comb begin
    w_inc = '0;
    w_any = 1'b0;
    for (int i = 0; i <= DW - PW; i++) begin
      if (i_mem_rdata[i +: PW] == r_pattern) begin
        w_inc = w_inc + SW'(1);
        w_any = 1'b1;
      end
    end
`ifdef PATCNT_CROSS_BYTE_EN
    w_cat = {i_mem_rdata, r_prev};
    if (r_have_prev) begin
      for (int j = 0; j < PW - 1; j++) begin
        if (w_cat[DW - PW + 1 + j +: PW] == r_pattern) begin
          w_inc = w_inc + SW'(1);
          w_any = 1'b1;
        end
      end
    end
`endif
    w_sum       = SW'(r_count) + (r_mode ? w_inc : SW'(w_any));
    w_count_nxt = (w_sum > SW'(c_MAX)) ? c_MAX : w_sum[CW-1:0];
  end

  // Datapath: parameter latch, read issue, evaluation and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern   <= '0;
      r_mode      <= 1'b0;
      r_left      <= '0;
      r_addr      <= '0;
      r_mem_rd    <= 1'b0;
      r_vld       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
`ifdef PATCNT_CROSS_BYTE_EN
      r_prev      <= '0;
      r_have_prev <= 1'b0;
`endif
    end else begin
      r_vld <= r_mem_rd;
      if (w_accept) begin
        r_pattern   <= i_pattern;
        r_mode      <= i_mode;
        r_count     <= '0;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
`ifdef PATCNT_CROSS_BYTE_EN
        r_prev      <= '0;
        r_have_prev <= 1'b0;
`endif
        if (i_length != '0) begin
          r_mem_rd <= 1'b1;
          r_addr   <= i_base_addr;
          r_left   <= i_length - AW'(1);
        end else begin
          r_mem_rd <= 1'b0;
        end
      end else begin
        case (r_state)
          RUN: begin
            if (r_left != '0) begin
              r_addr   <= r_addr + AW'(1);
              r_left   <= r_left - AW'(1);
              r_mem_rd <= 1'b1;
            end else begin
              r_mem_rd <= 1'b0;
            end
          end
          DRAIN: begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
          DONE:    r_done <= 1'b0;
          default: r_mem_rd <= 1'b0;
        endcase
        if (r_vld) begin
          r_count     <= w_count_nxt;
`ifdef PATCNT_CROSS_BYTE_EN
          r_prev      <= i_mem_rdata;
          r_have_prev <= 1'b1;
`endif
        end
      end
    end
  end

  assign o_mem_rd   = r_mem_rd;
  assign o_mem_addr = r_addr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pattern_count_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_count_engine
// Brief    : Directed table-driven bench for pattern_count_engine; a CW=4
//            instance shares all inputs to exercise count saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_count_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] length;
  logic [3:0] pattern;
  logic       mode;
  logic [7:0] rdata;

  logic       rd8, busy8, done8;
  logic [7:0] addr8, count8;
  logic       rd4, busy4, done4;
  logic [7:0] addr4;
  logic [3:0] count4;

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    logic [3:0] pat;
    logic       mode;
    logic       inj;    // pulse a conflicting start mid-run
    int         exp;    // expected count, word-local windows only
    int         exp_x;  // expected count with cross-word windows
  } vec_t;

  vec_t tbl [9];

  pattern_count_engine #(.DW(8), .PW(4), .AW(8), .CW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_length(length), .i_pattern(pattern), .i_mode(mode),
    .o_mem_rd(rd8), .o_mem_addr(addr8), .i_mem_rdata(rdata),
    .o_busy(busy8), .o_done(done8), .o_count(count8)
  );

  pattern_count_engine #(.DW(8), .PW(4), .AW(8), .CW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_length(length), .i_pattern(pattern), .i_mode(mode),
    .o_mem_rd(rd4), .o_mem_addr(addr4), .i_mem_rdata(rdata),
    .o_busy(busy4), .o_done(done4), .o_count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle latency memory model.
  always @(posedge clk) if (rd8) rdata <= mem[addr8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t e, input string tag);
    int         n, k, done_n, exp;
    logic       addr_ok, busy_ok;
    logic [7:0] ea;
    @(negedge clk);
    base_addr = e.base; length = e.len; pattern = e.pat; mode = e.mode; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    base_addr = e.base + 8'd5; length = e.len + 8'd3; pattern = ~e.pat; mode = ~e.mode;
    n = 1; k = 0; done_n = 0; addr_ok = 1'b1; busy_ok = 1'b1;
    while (done_n == 0 && n < 300) begin
      if (rd8) begin
        ea = e.base + 8'(k);
        if (addr8 !== ea) addr_ok = 1'b0;
        k++;
      end
      if (done8) begin
        done_n = n;
        if (busy8 !== 1'b0 || rd8 !== 1'b0) busy_ok = 1'b0;
      end else if (busy8 !== 1'b1) busy_ok = 1'b0;
      if (e.inj && n == 2) begin
        start = 1'b1; base_addr = 8'h00; length = 8'd1; pattern = 4'h0; mode = ~e.mode;
      end
      if (n == 3) start = 1'b0;
      if (done_n == 0) begin
        @(negedge clk);
        n++;
      end
    end
`ifdef PATCNT_CROSS_BYTE_EN
    exp = e.exp_x;
`else
    exp = e.exp;
`endif
    check({tag, " done_latency"}, done_n, int'(e.len) + 2);
    check({tag, " reads"}, k, e.len);
    check({tag, " addr_seq"}, addr_ok, 1);
    check({tag, " busy"}, busy_ok, 1);
    check({tag, " count"}, count8, exp);
    check({tag, " count_cw4"}, count4, (exp > 15) ? 15 : exp);
    @(negedge clk);
    check({tag, " done_pulse"}, done8, 0);
    check({tag, " count_hold"}, count8, exp);
  endtask

  initial begin
    //          base   len    pat   mode  inj   exp exp_x
    tbl[0] = '{8'h20, 8'd4,  4'hF, 1'b1, 1'b0,  7, 10};
    tbl[1] = '{8'h20, 8'd4,  4'hF, 1'b0, 1'b0,  3,  3};
    tbl[2] = '{8'hFE, 8'd4,  4'hF, 1'b1, 1'b0,  7,  7};
    tbl[3] = '{8'h30, 8'd0,  4'hF, 1'b1, 1'b0,  0,  0};
    tbl[4] = '{8'h40, 8'd8,  4'hF, 1'b1, 1'b0, 40, 61};
    tbl[5] = '{8'h10, 8'd2,  4'hF, 1'b1, 1'b1,  0,  1};
    tbl[6] = '{8'h20, 8'd4,  4'h0, 1'b1, 1'b0,  7, 13};
    tbl[7] = '{8'h20, 8'd4,  4'h0, 1'b0, 1'b1,  3,  3};
    tbl[8] = '{8'h40, 8'd64, 4'hF, 1'b0, 1'b1, 64, 64};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hFF; mem[8'h21] = 8'h0F; mem[8'h22] = 8'h00; mem[8'h23] = 8'hF0;
    mem[8'hFE] = 8'hF0; mem[8'hFF] = 8'h00; mem[8'h00] = 8'h0F; mem[8'h01] = 8'hFF;
    mem[8'h10] = 8'h80; mem[8'h11] = 8'h07;
    for (int i = 8'h40; i < 8'h80; i++) mem[i] = 8'hFF;

    start = 1'b0; base_addr = '0; length = '0; pattern = '0; mode = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rd8, addr8, busy8, done8, count8, count4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_quiet", {rd8, done8, busy8}, 0);
    end

    for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Abort a long run with reset at cycle T+3, after a word has been counted.
    @(negedge clk);
    base_addr = 8'h40; length = 8'd64; pattern = 4'hF; mode = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_count", count8, 5);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {rd8, addr8, busy8, done8, count8}, 0);
    @(negedge clk);
    check("abort_hold", {rd8, busy8, done8, count8}, 0);
    rst_n = 1'b1;
    run(tbl[0], "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_count_engine.md
# pattern_count_engine

Hardware offload for the bit-pattern search-and-count job that the CPU currently runs in software. On `start`, it reads a contiguous range of data memory through a read port with one-cycle latency. It slides a PW-bit window across every DW-bit word, counts matches against `pattern`, and reports the count with a one-cycle `done` pulse. It sits beside the data memory as a second read master; the CPU stores the result itself.

## Interface
- `DW`, 8, data memory word width
- `PW`, 4, pattern width; must satisfy 1 ≤ PW ≤ DW
- `AW`, 8, data memory address width
- `CW`, 8, count width

- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: begin a search; sampled only in IDLE
- `base_addr` in AW: first word address; sampled with `start`
- `length` in AW: number of words to scan, 0..2^AW−1; sampled with `start`
- `pattern` in PW: pattern to match; sampled with `start`
- `mode` in 1: 0 = count words containing ≥1 match; 1 = count every matching window position; sampled with `start`
- `mem_rd` out 1: read strobe
- `mem_addr` out AW: read address
- `mem_rdata` in DW: read data, valid the cycle after `mem_rd`
- `busy` out 1: search in progress
- `done` out 1: one-cycle completion pulse
- `count` out CW: result; holds until the next accepted `start`

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE → RUN on `start`:
  - latch all inputs
  - clear `count`
  - set the issued-read counter to 0
- If `length`==0, IDLE → DRAIN directly; no reads are issued.
- RUN:
  - assert `mem_rd` with `mem_addr` = base_addr + k, for k = 0..length−1, one per cycle
  - the address wraps modulo 2^AW
  - after the last issue, go to DRAIN
- DRAIN: evaluate the final returned word, then go to DONE.
- DONE:
  - `done`=1 for exactly one cycle
  - return to IDLE
- Evaluation of each returned word w happens in the cycle after its read.
  - Windows are w[i+PW−1:i] for i = 0..DW−PW, giving DW−PW+1 positions.
  - mode 1 adds the number of matching windows.
  - mode 0 adds 1 if any window matches.
- `count` saturates at 2^CW−1 and never wraps.
- `start` while not IDLE is ignored; latched parameters do not change mid-run.
- Changing `pattern`, `mode`, `base_addr` or `length` inputs mid-run has no effect.
- `reset` asserted at any time forces:
  - IDLE
  - `count`=0, `busy`=0, `done`=0, `mem_rd`=0, `mem_addr`=0
- No partial result survives reset.

## Timing
- Reset values of all outputs are 0.
- `start` is accepted at edge T.
  - `busy`=1 from T+1.
  - Reads are issued in cycles T+1..T+L.
  - Data arrives in cycles T+2..T+L+1.
- `count` is final after edge T+L+1.
- `done`=1 in cycle T+L+2, and `busy` drops in that same cycle.
- Every run takes L+2 cycles from start to done. L=0 gives done at T+2 with count 0.
- `mem_rd` is never asserted outside RUN.
- `mem_addr` holds its last value when idle.
- The earliest next `start` is accepted at the edge ending the DONE cycle.
- All outputs are registered.

## Configuration
- `PATCNT_CROSS_BYTE_EN` defined:
  - Also evaluate the PW−1 windows that straddle consecutive words: {w_k[j:0], w_{k−1}[DW−1:DW−PW+1+j]} for j = 0..PW−2.
  - These windows apply for k ≥ 1 within a run only; the first word of a run has no predecessor.
  - Straddling matches are credited to word k for both modes.
  - This adds one DW-bit previous-word register, cleared on `start` and on `reset`.
- Undefined:
  - Windows never cross word boundaries.
  - No previous-word register.

## Test plan
- Reset: hold `reset`=0 → all outputs 0. Release, then wait 5 cycles idle → `mem_rd`=0 and `done`=0 throughout.
- base=0x20, length=4, pattern=4'b1111, words FF,0F,00,F0:
  - mode 1 → count=7 (5+1+0+1), done at T+6.
  - mode 0 → count=3.
- Wrap and zero length:
  - base=0xFE, length=4 → addresses FE,FF,00,01 on consecutive cycles.
  - length=0 → no `mem_rd`, done at T+2, count=0.
- Saturation: CW=4, length=8, all words FF, pattern 4'b1111, mode 1 → count=15, not 40 mod 16.
- Mid-run abort: `reset`=0 at cycle T+3 of a length-64 run → IDLE immediately, count=0. A new start then completes normally with the correct count.
- `PATCNT_CROSS_BYTE_EN`: words 80,07, pattern 4'b1111, mode 1:
  - defined → count=1
  - undefined → count=0
  - a `start` pulse mid-run is ignored in both builds.
